// File: rtl/lookup_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lookup_pkg
// Description : Shared definitions for the pipelined tree lookup. Node word
//               field placement (also used by the BRAM init scripts) and the
//               lookup bundle carried between levels at the default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package lookup_pkg;

    // Default widths of the production tree
    localparam int LK_KEY    = 32;
    localparam int LK_ADDR   = 10;
    localparam int LK_RESULT = 16;

    // Node word layout: [KEY-1:0] pivot, [KEY+RESULT-1:KEY] result,
    // [KEY+RESULT] leaf_match; anything above is ignored.
    localparam int PIVOT_LSB  = 0;
    localparam int RESULT_LSB = LK_KEY;
    localparam int LEAF_BIT   = LK_KEY + LK_RESULT;

    // Same layout for arbitrary widths
    function automatic int result_lsb(input int key_w);
        return key_w;
    endfunction

    function automatic int leaf_bit(input int key_w, input int result_w);
        return key_w + result_w;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [LK_KEY-1:0]    key;
        logic [LK_ADDR-1:0]   addr;
        logic                 found;
        logic [LK_RESULT-1:0] result;
    } lookup_t;

endpackage
`default_nettype wire

// File: rtl/lookup_node_cmp.sv
`default_nettype none
// ============================================================================
// Module      : lookup_node_cmp
// Description : Combinational node evaluation for one tree level. Produces
//               the branch direction and the running match/result.
//   i_key, i_pivot        search key and node pivot
//   i_node_result         result stored in the node
//   i_leaf_match          node may terminate the search on key == pivot
//   i_found, i_result     match state from earlier levels
//   o_dir                 1 = right child (key >= pivot)
//   o_found, o_result     match state after this level
// Revision    : 1.0 - initial release
// ============================================================================
module lookup_node_cmp #(
    parameter int KEY    = 32,
    parameter int RESULT = 16
) (
    input  logic [KEY-1:0]    i_key,
    input  logic [KEY-1:0]    i_pivot,
    input  logic [RESULT-1:0] i_node_result,
    input  logic              i_leaf_match,
    input  logic              i_found,
    input  logic [RESULT-1:0] i_result,
    output logic              o_dir,
    output logic              o_found,
    output logic [RESULT-1:0] o_result
);

    // Once a lookup has matched, its walk down the remaining levels is pinned
    // to the left child so later levels see a deterministic address.
    always_comb begin
        o_found  = i_found;
        o_result = i_result;
        o_dir    = 1'b0;
        if (!i_found) begin
            if (i_leaf_match && (i_key == i_pivot)) begin
                o_found  = 1'b1;
                o_result = i_node_result;
            end else begin
                o_dir = (i_key >= i_pivot);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lookup_stage.sv
`default_nettype none
// ============================================================================
// Module      : lookup_stage
// Description : One level of the pipelined tree lookup. Reads the level's
//               node from BRAM port A, compares key vs pivot and emits the
//               child address {in_addr, dir}. Table updates are registered
//               once and issued on BRAM port B. Fixed latency of 2 cycles,
//               no backpressure.
//   clk, rst              clock, asynchronous active-high reset
//   in_*                  lookup from the previous level
//   out_*                 lookup to the next level
//   mem_a_addr/mem_a_dout BRAM read port (1-cycle read latency)
//   upd_*                 table write request from the control path
//   mem_b_*               BRAM write port
// Revision    : 1.0 - initial release
// ============================================================================
module lookup_stage
    import lookup_pkg::*;
#(
    parameter int STAGE_ID = 0,
    parameter int ADDR     = 10,
    parameter int DATA     = 72,
    parameter int KEY      = 32,
    parameter int RESULT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [KEY-1:0]    in_key,
    input  logic [ADDR-1:0]   in_addr,
    input  logic              in_found,
    input  logic [RESULT-1:0] in_result,
    output logic              out_valid,
    output logic [KEY-1:0]    out_key,
    output logic [ADDR:0]     out_addr,
    output logic              out_found,
    output logic [RESULT-1:0] out_result,
    output logic [ADDR-1:0]   mem_a_addr,
    input  logic [DATA-1:0]   mem_a_dout,
    input  logic              upd_valid,
    input  logic [ADDR-1:0]   upd_addr,
    input  logic [DATA-1:0]   upd_data,
    output logic              mem_b_wr,
    output logic [ADDR-1:0]   mem_b_addr,
    output logic [DATA-1:0]   mem_b_din
);

    localparam int c_RES_LSB = result_lsb(KEY);
    localparam int c_LEAF    = leaf_bit(KEY, RESULT);
    localparam int c_NODE_W  = c_LEAF + 1;

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (DATA < c_NODE_W) begin : g_bad_data_w
        $error("lookup_stage: DATA too narrow for KEY+RESULT+1");
    end
    if (STAGE_ID < 0) begin : g_bad_stage_id
        $error("lookup_stage: STAGE_ID must be non-negative");
    end

    // Upper node bits carry no meaning for the lookup
    if (DATA > c_NODE_W) begin : g_dout_pad
        logic w_unused_dout;
        assign w_unused_dout = &{1'b0, mem_a_dout[DATA-1:c_NODE_W]};
    end

    // ------------------------------------------------------------------
    // Update path: one register stage straight onto port B
    // ------------------------------------------------------------------
    logic            r_upd_wr;
    logic [ADDR-1:0] r_upd_addr;
    logic [DATA-1:0] r_upd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_upd_wr   <= 1'b0;
            r_upd_addr <= '0;
            r_upd_data <= '0;
        end else begin
            r_upd_wr   <= upd_valid;
            r_upd_addr <= upd_addr;
            r_upd_data <= upd_data;
        end
    end

    assign mem_b_wr   = r_upd_wr;
    assign mem_b_addr = r_upd_addr;
    assign mem_b_din  = r_upd_data;
    assign mem_a_addr = in_addr;

    // A write on port B to the address being read this edge: the BRAM
    // returns the old word, so the new node is captured and forwarded.
    logic w_collide;
    assign w_collide = r_upd_wr && (r_upd_addr == in_addr);

    // ------------------------------------------------------------------
    // Stage 1: lookup fields aligned with the BRAM read latency
    // ------------------------------------------------------------------
    logic                r_s1_valid;
    logic [KEY-1:0]      r_s1_key;
    logic [ADDR-1:0]     r_s1_addr;
    logic                r_s1_found;
    logic [RESULT-1:0]   r_s1_result;
    logic                r_s1_fwd;
    logic [c_NODE_W-1:0] r_s1_fwd_node;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_key      <= '0;
            r_s1_addr     <= '0;
            r_s1_found    <= 1'b0;
            r_s1_result   <= '0;
            r_s1_fwd      <= 1'b0;
            r_s1_fwd_node <= '0;
        end else begin
            r_s1_valid    <= in_valid;
            r_s1_key      <= in_key;
            r_s1_addr     <= in_addr;
            r_s1_found    <= in_found;
            r_s1_result   <= in_result;
            r_s1_fwd      <= w_collide;
            r_s1_fwd_node <= r_upd_data[c_NODE_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Compare
    // ------------------------------------------------------------------
    logic [c_NODE_W-1:0] w_node;
    logic                w_dir;
    logic                w_found;
    logic [RESULT-1:0]   w_result;

    assign w_node = r_s1_fwd ? r_s1_fwd_node : mem_a_dout[c_NODE_W-1:0];

    lookup_node_cmp #(
        .KEY    (KEY),
        .RESULT (RESULT)
    ) u_cmp (
        .i_key         (r_s1_key),
        .i_pivot       (w_node[PIVOT_LSB +: KEY]),
        .i_node_result (w_node[c_RES_LSB +: RESULT]),
        .i_leaf_match  (w_node[c_LEAF]),
        .i_found       (r_s1_found),
        .i_result      (r_s1_result),
        .o_dir         (w_dir),
        .o_found       (w_found),
        .o_result      (w_result)
    );

    // ------------------------------------------------------------------
    // Output register; payload holds while no lookup is presented
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_key    <= '0;
            out_addr   <= '0;
            out_found  <= 1'b0;
            out_result <= '0;
        end else begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_key    <= r_s1_key;
                out_addr   <= {r_s1_addr, w_dir};
                out_found  <= w_found;
                out_result <= w_result;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lookup_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_lookup_stage
// Description : Self-checking bench for lookup_stage. A behavioural table
//               and an expected-output queue predict every output cycle;
//               a read-first BRAM model sits on the memory ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lookup_stage;

    localparam int ADDR   = 10;
    localparam int DATA   = 72;
    localparam int KEY    = 32;
    localparam int RESULT = 16;
    localparam int DEPTH  = 1 << ADDR;

    typedef struct packed {
        logic              valid;
        logic [KEY-1:0]    key;
        logic [ADDR:0]     addr;
        logic              found;
        logic [RESULT-1:0] result;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [KEY-1:0]    in_key = '0;
    logic [ADDR-1:0]   in_addr = '0;
    logic              in_found = 1'b0;
    logic [RESULT-1:0] in_result = '0;
    logic              out_valid;
    logic [KEY-1:0]    out_key;
    logic [ADDR:0]     out_addr;
    logic              out_found;
    logic [RESULT-1:0] out_result;
    logic [ADDR-1:0]   mem_a_addr;
    logic [DATA-1:0]   mem_a_dout = '0;
    logic              upd_valid = 1'b0;
    logic [ADDR-1:0]   upd_addr = '0;
    logic [DATA-1:0]   upd_data = '0;
    logic              mem_b_wr;
    logic [ADDR-1:0]   mem_b_addr;
    logic [DATA-1:0]   mem_b_din;

    always #5 clk = ~clk;

    lookup_stage #(
        .STAGE_ID (0),
        .ADDR     (ADDR),
        .DATA     (DATA),
        .KEY      (KEY),
        .RESULT   (RESULT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_key     (in_key),
        .in_addr    (in_addr),
        .in_found   (in_found),
        .in_result  (in_result),
        .out_valid  (out_valid),
        .out_key    (out_key),
        .out_addr   (out_addr),
        .out_found  (out_found),
        .out_result (out_result),
        .mem_a_addr (mem_a_addr),
        .mem_a_dout (mem_a_dout),
        .upd_valid  (upd_valid),
        .upd_addr   (upd_addr),
        .upd_data   (upd_data),
        .mem_b_wr   (mem_b_wr),
        .mem_b_addr (mem_b_addr),
        .mem_b_din  (mem_b_din)
    );

    // Read-first dual-port BRAM
    logic [DATA-1:0] bram [DEPTH];
    always @(posedge clk) begin
        mem_a_dout <= bram[mem_a_addr];
        if (mem_b_wr) bram[mem_b_addr] <= mem_b_din;
    end

    // Reference state
    logic [DATA-1:0] ref_tbl [DEPTH];
    exp_t            pipe [$];
    exp_t            last;
    logic            pend_v;
    logic [ADDR-1:0] pend_a;
    logic [DATA-1:0] pend_d;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA-1:0] mk_node(input logic leaf, input logic [RESULT-1:0] res,
                                                input logic [KEY-1:0] pivot);
        logic [DATA-1:0] n;
        n = DATA'({$urandom, $urandom, $urandom});
        n[KEY-1:0]            = pivot;
        n[KEY+RESULT-1:KEY]   = res;
        n[KEY+RESULT]         = leaf;
        return n;
    endfunction

    function automatic void model_reset();
        exp_t z;
        z = '0;
        pipe.delete();
        pipe.push_back(z);
        pipe.push_back(z);
        last   = '0;
        pend_v = 1'b0;
        pend_a = '0;
        pend_d = '0;
    endfunction

    // One clock cycle: check the outputs due now, then apply new inputs
    task automatic step(input logic iv, input logic [KEY-1:0] k, input logic [ADDR-1:0] a,
                        input logic f, input logic [RESULT-1:0] r,
                        input logic uv, input logic [ADDR-1:0] ua, input logic [DATA-1:0] ud);
        exp_t            e;
        exp_t            x;
        logic [DATA-1:0] node;
        logic [KEY-1:0]  pivot;
        logic            dir;
        @(negedge clk);
        e = pipe.pop_front();
        if (e.valid) last = e;
        chk("out_valid",  128'(out_valid),  128'(e.valid));
        chk("out_key",    128'(out_key),    128'(last.key));
        chk("out_addr",   128'(out_addr),   128'(last.addr));
        chk("out_found",  128'(out_found),  128'(last.found));
        chk("out_result", 128'(out_result), 128'(last.result));
        chk("mem_b_wr",   128'(mem_b_wr),   128'(pend_v));
        if (pend_v) begin
            chk("mem_b_addr", 128'(mem_b_addr), 128'(pend_a));
            chk("mem_b_din",  128'(mem_b_din),  128'(pend_d));
            // This write lands on the same edge that samples the new lookup
            ref_tbl[pend_a] = pend_d;
        end
        x = '0;
        x.valid = iv;
        if (iv) begin
            node  = ref_tbl[a];
            pivot = node[KEY-1:0];
            x.key = k;
            dir   = 1'b0;
            if (f) begin
                x.found  = 1'b1;
                x.result = r;
            end else if (node[KEY+RESULT] && k == pivot) begin
                x.found  = 1'b1;
                x.result = node[KEY+RESULT-1:KEY];
            end else begin
                x.found  = 1'b0;
                x.result = r;
                dir      = (k >= pivot);
            end
            x.addr = (ADDR+1)'(a) * (ADDR+1)'(2) + (ADDR+1)'(dir);
        end
        pipe.push_back(x);
        pend_v = uv;
        pend_a = ua;
        pend_d = ud;
        in_valid  = iv;
        in_key    = k;
        in_addr   = a;
        in_found  = f;
        in_result = r;
        upd_valid = uv;
        upd_addr  = ua;
        upd_data  = ud;
        #1;
        chk("mem_a_addr", 128'(mem_a_addr), 128'(a));
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic look(input logic [KEY-1:0] k, input logic [ADDR-1:0] a,
                        input logic f, input logic [RESULT-1:0] r);
        step(1'b1, k, a, f, r, 1'b0, '0, '0);
    endtask

    task automatic upd(input logic [ADDR-1:0] ua, input logic [DATA-1:0] ud);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, ua, ud);
    endtask

    task automatic rand_step(input logic iv);
        logic [ADDR-1:0]   a;
        logic [KEY-1:0]    k;
        logic [KEY-1:0]    p;
        int                sel;
        a   = ADDR'($urandom_range(0, 15));
        p   = ref_tbl[a][KEY-1:0];
        sel = int'($urandom_range(0, 2));
        if (sel == 0)      k = p;
        else if (sel == 1) k = p + KEY'($urandom_range(0, 2)) - KEY'(1);
        else               k = $urandom;
        step(iv, k, a, ($urandom_range(0, 3) == 0), RESULT'($urandom),
             ($urandom_range(0, 2) == 0), ADDR'($urandom_range(0, 15)),
             mk_node(1'($urandom), RESULT'($urandom), $urandom_range(0, 1) ? p : KEY'($urandom)));
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_mem_b_wr",  128'(mem_b_wr),  128'(0));
        chk("rst_out_addr",  128'(out_addr),  128'(0));
        chk("rst_out_found", 128'(out_found), 128'(0));
        repeat (3) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_addr   = ADDR'($urandom_range(0, 15));
            upd_valid = 1'b1;
            upd_addr  = ADDR'($urandom_range(0, 15));
            upd_data  = mk_node(1'b0, '0, $urandom);
            chk("rst_hold_valid", 128'(out_valid), 128'(0));
            chk("rst_hold_wr",    128'(mem_b_wr),  128'(0));
        end
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        upd_valid = 1'b0;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_tbl[i] = mk_node(1'($urandom), RESULT'($urandom), $urandom);
            bram[i]    = ref_tbl[i];
        end

        // Power-on reset
        repeat (3) @(negedge clk);
        chk("por_out_valid",  128'(out_valid),  128'(0));
        chk("por_out_found",  128'(out_found),  128'(0));
        chk("por_out_key",    128'(out_key),    128'(0));
        chk("por_out_addr",   128'(out_addr),   128'(0));
        chk("por_out_result", 128'(out_result), 128'(0));
        chk("por_mem_b_wr",   128'(mem_b_wr),   128'(0));
        chk("por_mem_b_addr", 128'(mem_b_addr), 128'(0));
        chk("por_mem_b_din",  128'(mem_b_din),  128'(0));
        rst = 1'b0;
        model_reset();

        // Load directed nodes through the update path
        upd(10'd5, mk_node(1'b0, 16'h0000, 32'd100));
        upd(10'd7, mk_node(1'b0, 16'h0000, 32'd200));
        upd(10'd3, mk_node(1'b1, 16'hBEEF, 32'h1234));
        upd(10'd9, mk_node(1'b1, 16'h1111, 32'h0077));
        idle();

        // Left / right
        look(32'd99, 10'd5, 1'b0, '0);
        look(32'd100, 10'd5, 1'b0, '0);
        idle();
        chk("basic_left_addr",  128'(out_addr),  128'(10));
        chk("basic_left_found", 128'(out_found), 128'(0));
        idle();
        chk("basic_right_addr", 128'(out_addr),  128'(11));

        // Leaf match
        look(32'h1234, 10'd3, 1'b0, 16'h0000);
        idle();
        idle();
        chk("match_found",  128'(out_found),  128'(1));
        chk("match_result", 128'(out_result), 128'(16'hBEEF));
        chk("match_addr",   128'(out_addr),   128'(6));

        // Earlier match passes through
        look(32'h0077, 10'd9, 1'b1, 16'h55AA);
        idle();
        idle();
        chk("pass_found",  128'(out_found),  128'(1));
        chk("pass_result", 128'(out_result), 128'(16'h55AA));
        chk("pass_addr",   128'(out_addr),   128'(18));

        // Port-B write hitting the read address on the same edge
        upd(10'd7, mk_node(1'b0, 16'h0000, 32'd50));
        look(32'd60, 10'd7, 1'b0, '0);
        idle();
        idle();
        chk("collide_addr", 128'(out_addr), 128'(15));

        // Update issued with the lookup lands after the read edge
        upd(10'd7, mk_node(1'b0, 16'h0000, 32'd250));
        idle();
        step(1'b1, 32'd240, 10'd7, 1'b0, '0, 1'b1, 10'd7, mk_node(1'b0, 16'h0000, 32'd10));
        idle();
        idle();
        chk("late_write_addr", 128'(out_addr), 128'(14));

        // Streaming, one lookup every cycle
        repeat (100) rand_step(1'b1);

        // Reset with lookups and an update in flight
        look($urandom, 10'd2, 1'b0, '0);
        step(1'b1, $urandom, 10'd4, 1'b0, '0, 1'b1, 10'd4, mk_node(1'b0, '0, $urandom));
        mid_reset();

        // Sparse random traffic after recovery
        repeat (40) rand_step(1'($urandom));
        repeat (3) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
